// File: rtl/adder_share_pkg.sv
// adder_share_pkg: shared constants and cyclic priority helper for the shared mantissa adder
package adder_share_pkg;
    localparam int MANT_W = 23;
    localparam int NUM_REQ_DEF = 4;
    localparam int ID_W_DEF = 2;

    function automatic int rr_slot(input int ptr, input int off, input int n);
        return (ptr + off) % n;
    endfunction
endpackage

// File: rtl/adder_23bit.sv
// adder_23bit: combinational 23-bit ripple-carry adder
module adder_23bit (
    input  logic [22:0] a,
    input  logic [22:0] b,
    input  logic        cin,
    output logic [22:0] sum,
    output logic        cout
);
    logic [23:0] c;
    // ripple the carry bit by bit from the lsb
    always_comb begin
        c[0] = cin;
        for (int i = 0; i < 23; i++) begin
            sum[i] = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end
    assign cout = c[23];
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant with pointer advancing past each winner
module rr_arbiter
    import adder_share_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ID_W = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id
);
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] k;
    // scan from the farthest slot back to ptr so the nearest requester wins
    always_comb begin
        grant = '0;
        grant_id = '0;
        k = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            k = ID_W'(rr_slot(int'(ptr), j, NUM_REQ));
            if (req[k]) begin
                grant = '0;
                grant[k] = 1'b1;
                grant_id = k;
            end
        end
    end
    // pointer moves to the slot after the accepted requester
    always_ff @(posedge clk) begin
        if (!rst_n) ptr <= '0;
        else if (advance) ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    end
endmodule

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: round-robin sharing of one 23-bit adder with a registered, tagged result
module adder_share_arbiter
    import adder_share_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ID_W = ID_W_DEF,
    parameter int CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*MANT_W-1:0] req_a,
    input  logic [NUM_REQ*MANT_W-1:0] req_b,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [MANT_W-1:0]         res_sum,
    output logic                      res_carry,
    output logic [ID_W-1:0]           res_id,
    output logic [CNT_W-1:0]          op_count
);
    logic               can_load;
    logic               xfer;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic [MANT_W-1:0]  a_sel;
    logic [MANT_W-1:0]  b_sel;
    logic [MANT_W-1:0]  sum;
    logic               carry;

    assign can_load  = !res_valid || res_ready;
    assign req_ready = (rst_n && can_load) ? grant : '0;
    assign xfer      = |(req_valid & req_ready);
    assign a_sel     = req_a[grant_id*MANT_W +: MANT_W];
    assign b_sel     = req_b[grant_id*MANT_W +: MANT_W];

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .clk(clk),
        .rst_n(rst_n),
        .req(req_valid),
        .advance(xfer),
        .grant(grant),
        .grant_id(grant_id)
    );

    adder_23bit u_add (
        .a(a_sel),
        .b(b_sel),
        .cin(1'b0),
        .sum(sum),
        .cout(carry)
    );

    // single-entry result buffer; a load overwrites while draining, a bare drain empties it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_sum <= '0;
            res_carry <= 1'b0;
            res_id <= '0;
            op_count <= '0;
        end else begin
            if (xfer) begin
                res_valid <= 1'b1;
                res_sum <= sum;
                res_carry <= carry;
                res_id <= grant_id;
            end else if (res_ready) begin
                res_valid <= 1'b0;
            end
            if (res_valid && res_ready && op_count != '1) op_count <= op_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb_adder_share_arbiter: directed checks of arbitration, backpressure, saturation and reset
module tb_adder_share_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [91:0] req_a;
    logic [91:0] req_b;
    logic        res_valid;
    logic        res_ready;
    logic [22:0] res_sum;
    logic        res_carry;
    logic [1:0]  res_id;
    logic [3:0]  op_count;

    logic [22:0] op_a [4];
    logic [22:0] op_b [4];
    logic [22:0] exp_s [4];
    logic        exp_c [4];
    int          total = 0;
    int          passed = 0;

    assign req_a = {op_a[3], op_a[2], op_a[1], op_a[0]};
    assign req_b = {op_b[3], op_b[2], op_b[1], op_b[0]};

    always #5 clk = ~clk;

    adder_share_arbiter #(.NUM_REQ(4), .ID_W(2), .CNT_W(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a(req_a),
        .req_b(req_b),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_sum(res_sum),
        .res_carry(res_carry),
        .res_id(res_id),
        .op_count(op_count)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        else passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_table();
        op_a[0] = 23'h000005; op_b[0] = 23'h000003; exp_s[0] = 23'h000008; exp_c[0] = 1'b0;
        op_a[1] = 23'h400000; op_b[1] = 23'h400000; exp_s[1] = 23'h000000; exp_c[1] = 1'b1;
        op_a[2] = 23'h7FFFFF; op_b[2] = 23'h000002; exp_s[2] = 23'h000001; exp_c[2] = 1'b1;
        op_a[3] = 23'h123456; op_b[3] = 23'h111111; exp_s[3] = 23'h234567; exp_c[3] = 1'b0;
    endtask

    initial begin
        load_table();
        rst_n = 1'b0;
        req_valid = 4'hF;
        res_ready = 1'b1;
        tick();
        tick();
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_res_valid", 32'(res_valid), 32'h0);
        chk("rst_op_count", 32'(op_count), 32'h0);
        chk("rst_res_sum", 32'(res_sum), 32'h0);
        rst_n = 1'b1;
        #1;
        chk("first_grant", 32'(req_ready), 32'h1);
        for (int k = 0; k < 8; k++) begin
            chk("rr_ready", 32'(req_ready), 32'(4'b0001 << (k % 4)));
            tick();
            chk("rr_valid", 32'(res_valid), 32'h1);
            chk("rr_id", 32'(res_id), 32'(k % 4));
            chk("rr_sum", 32'(res_sum), 32'(exp_s[k % 4]));
            chk("rr_carry", 32'(res_carry), 32'(exp_c[k % 4]));
        end
        req_valid = 4'h0;
        tick();
        chk("rr_op_count", 32'(op_count), 32'd8);
        chk("drain_valid", 32'(res_valid), 32'h0);
        op_a[2] = 23'h000001;
        op_b[2] = 23'h7FFFFF;
        req_valid = 4'b0100;
        #1;
        chk("single_ready", 32'(req_ready), 32'b0100);
        tick();
        chk("single_valid", 32'(res_valid), 32'h1);
        chk("single_sum", 32'(res_sum), 32'h0);
        chk("single_carry", 32'(res_carry), 32'h1);
        chk("single_id", 32'(res_id), 32'h2);
        load_table();
        res_ready = 1'b0;
        req_valid = 4'hF;
        #1;
        chk("bp_ready", 32'(req_ready), 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_valid", 32'(res_valid), 32'h1);
            chk("bp_sum", 32'(res_sum), 32'h0);
            chk("bp_carry", 32'(res_carry), 32'h1);
            chk("bp_id", 32'(res_id), 32'h2);
            chk("bp_hold_ready", 32'(req_ready), 32'h0);
        end
        res_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(req_ready), 32'b1000);
        tick();
        chk("bp_next_valid", 32'(res_valid), 32'h1);
        chk("bp_next_id", 32'(res_id), 32'h3);
        chk("bp_next_sum", 32'(res_sum), 32'h234567);
        chk("bp_op_count", 32'(op_count), 32'd9);
        req_valid = 4'b0010;
        #1;
        chk("skip_setup_ready", 32'(req_ready), 32'b0010);
        tick();
        chk("skip_setup_id", 32'(res_id), 32'h1);
        req_valid = 4'b1010;
        #1;
        chk("skip_ready_3", 32'(req_ready), 32'b1000);
        tick();
        chk("skip_id_3", 32'(res_id), 32'h3);
        chk("skip_ready_1", 32'(req_ready), 32'b0010);
        tick();
        chk("skip_id_1", 32'(res_id), 32'h1);
        req_valid = 4'hF;
        #1;
        chk("skip_ptr_2", 32'(req_ready), 32'b0100);
        chk("skip_op_count", 32'(op_count), 32'd12);
        for (int k = 0; k < 20; k++) tick();
        chk("sat_op_count", 32'(op_count), 32'd15);
        chk("sat_valid", 32'(res_valid), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", 32'(req_ready), 32'h0);
        tick();
        chk("midrst_valid", 32'(res_valid), 32'h0);
        chk("midrst_op_count", 32'(op_count), 32'h0);
        chk("midrst_id", 32'(res_id), 32'h0);
        rst_n = 1'b1;
        #1;
        chk("midrst_ptr_0", 32'(req_ready), 32'h1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
